// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared size encodings, FSM states and memory depth for the load/store unit.
package mips_mem_pkg;
   localparam int MEM_WORDS_DEFAULT = 64;
   typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;
   typedef enum logic [2:0] {IDLE, LOAD, RD, WR, RESP} state_e;
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake between the MEM stage and the load/store unit.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   modport master (output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
                   input req_ready, resp_valid, resp_rdata, resp_error);
   modport slave (input req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
                  output req_ready, resp_valid, resp_rdata, resp_error);
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extract/extend for loads and lane merge for sub-word stores.
module lsu_lane_align
   import mips_mem_pkg::*;
(
   input  logic [1:0]  i_off,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [31:0] i_rdata,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_ldata,
   output logic [31:0] o_merged
);
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   always_comb begin
      w_byte   = i_rdata[{i_off, 3'b000} +: 8];
      w_half   = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
      o_ldata  = i_size == SZ_BYTE ? {{24{w_byte[7] & ~i_unsigned}}, w_byte}
               : i_size == SZ_HALF ? {{16{w_half[15] & ~i_unsigned}}, w_half} : i_rdata;
      o_merged = i_wdata;
      if (i_size == SZ_BYTE) begin
         o_merged = i_rdata;
         o_merged[{i_off, 3'b000} +: 8] = i_wdata[7:0];
      end else if (i_size == SZ_HALF) begin
         o_merged = i_rdata;
         o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequences MEM-stage loads/stores onto a word-only data memory,
// doing read-modify-write for sub-word stores and rejecting bad accesses.
module load_store_unit
   import mips_mem_pkg::*;
#(
   parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   load_store_unit_if.slave   bus,
   output logic               MemWrite,
   output logic [31:0]        Address,
   output logic [31:0]        WriteData,
   input  logic [31:0]        ReadData
);
   state_e      r_state;
   logic [31:0] r_addr, r_wdata, r_merge, r_rdata;
   logic [1:0]  r_size;
   logic        r_unsigned, r_error;
   logic        w_err;
   logic [31:0] w_ldata, w_merged;

   assign w_err = bus.req_size == SZ_RSVD
                | (bus.req_size == SZ_HALF & bus.req_addr[0])
                | (bus.req_size == SZ_WORD & |bus.req_addr[1:0])
                | bus.req_addr >= 32'(4 * MEM_WORDS);

   lsu_lane_align u_align (
      .i_off      (r_addr[1:0]),
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .i_rdata    (ReadData),
      .i_wdata    (r_wdata),
      .o_ldata    (w_ldata),
      .o_merged   (w_merged)
   );

   // The merge register doubles as the write-data register so WriteData holds between stores.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_merge    <= '0;
         r_rdata    <= '0;
         r_size     <= '0;
         r_unsigned <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (bus.req_valid) begin
               r_addr     <= bus.req_addr;
               r_size     <= bus.req_size;
               r_unsigned <= bus.req_unsigned;
               r_wdata    <= bus.req_wdata;
               r_error    <= w_err;
               r_rdata    <= '0;
               r_state    <= w_err ? RESP : !bus.req_write ? LOAD : bus.req_size == SZ_WORD ? WR : RD;
               if (!w_err && bus.req_write && bus.req_size == SZ_WORD) r_merge <= bus.req_wdata;
            end
            LOAD: begin
               r_rdata <= w_ldata;
               r_state <= RESP;
            end
            RD: begin
               r_merge <= w_merged;
               r_state <= WR;
            end
            WR:      r_state <= RESP;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = r_state == IDLE;
   assign bus.resp_valid = r_state == RESP;
   assign bus.resp_rdata = r_rdata;
   assign bus.resp_error = r_error;
   assign MemWrite       = r_state == WR;
   assign Address        = r_addr;
   assign WriteData      = r_merge;
endmodule
